// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// a small helper that classifies which opcodes take the multi-cycle path.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    // Single-cycle ops go straight from IDLE to DONE, so no EXEC state exists.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic v;
        logic c;
        logic z;
        logic n;
    } flags_t;

    // True when the opcode is serviced by the iterative multiplier.
    function automatic logic is_multicycle(input logic [2:0] op, input logic mul_en);
        return mul_en && (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch (master) and the ALU (slave):
// request channel in_valid/in_ready with op/a/b, response channel
// out_valid/out_ready with result and V/C/Z/N flags.
interface alu_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         v;
    logic         c;
    logic         z;
    logic         n;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, v, c, z, n
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, v, c, z, n
    );
endinterface

// File: rtl/alu_seq_addsub.sv
// Combinational ripple add/subtract shared by ADD, SUB and SLT.
// sub_i=1 computes a + ~b + 1; cout_o is the carry out of the MSB
// (1 = no borrow when subtracting), v_o is signed overflow.
module addsub_n #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         v_o
);
    logic [W-1:0] b_x;
    logic [W:0]   carry;

    assign carry[0] = sub_i;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign b_x[gi]       = b_i[gi] ^ sub_i;
            assign sum_o[gi]     = a_i[gi] ^ b_x[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_i[gi] & b_x[gi]) | (carry[gi] & (a_i[gi] ^ b_x[gi]));
        end
    endgenerate

    assign cout_o = carry[W];
    // Carry into the MSB differing from carry out of it is exactly the
    // "same-sign operands, different-sign result" overflow condition.
    assign v_o    = carry[W] ^ carry[W-1];
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: ADD/SUB/AND/OR/XOR/SLT complete on the accept edge,
// MUL iterates one partial product per cycle for W cycles. Result and
// flags are registered and held in DONE until the consumer takes them.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W      = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int            CW       = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e          state_q;
    logic            out_valid_q;
    logic [W-1:0]    result_q;
    flags_t          flags_q;

    logic [W-1:0]    mcand_q;
    logic [W-1:0]    mplier_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;

    logic [W-1:0]    as_sum;
    logic            as_cout;
    logic            as_v;

    logic [W-1:0]    alu_r_d;
    logic            alu_v_d;
    logic            alu_c_d;

    logic [W-1:0]    mul_pp_d;
    logic [W:0]      mul_hi_d;
    logic [2*W-1:0]  mul_acc_d;
    logic            mul_sel;

    addsub_n #(.W(W)) u_addsub (
        .a_i    (bus.a),
        .b_i    (bus.b),
        .sub_i  (bus.op != OP_ADD),
        .sum_o  (as_sum),
        .cout_o (as_cout),
        .v_o    (as_v)
    );

    assign mul_sel       = is_multicycle(bus.op, MUL_EN);
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.v         = flags_q.v;
    assign bus.c         = flags_q.c;
    assign bus.z         = flags_q.z;
    assign bus.n         = flags_q.n;

    // Single-cycle result and V/C for the op presented on the bus.
    always_comb begin
        alu_r_d = '0;
        alu_v_d = 1'b0;
        alu_c_d = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                alu_r_d = as_sum;
                alu_c_d = as_cout;
                alu_v_d = as_v;
            end
            OP_AND: alu_r_d = bus.a & bus.b;
            OP_OR:  alu_r_d = bus.a | bus.b;
            OP_XOR: alu_r_d = bus.a ^ bus.b;
            // Sign of a-b corrected by overflow gives the true signed compare.
            OP_SLT: alu_r_d = {{(W-1){1'b0}}, as_sum[W-1] ^ as_v};
            default: alu_r_d = '0;
        endcase
    end

    // One shift-add step: add the multiplicand into the upper half when
    // the current multiplier bit is set, then shift the accumulator right.
    always_comb begin
        mul_pp_d  = mplier_q[0] ? mcand_q : '0;
        mul_hi_d  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_pp_d};
        mul_acc_d = {mul_hi_d, acc_q[W-1:1]};
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (mul_sel) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= ST_MUL;
                        end else begin
                            result_q    <= alu_r_d;
                            flags_q.v   <= alu_v_d;
                            flags_q.c   <= alu_c_d;
                            flags_q.z   <= (alu_r_d == '0);
                            flags_q.n   <= alu_r_d[W-1];
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= mul_acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= mul_acc_d[W-1:0];
                        flags_q.v   <= 1'b0;
                        flags_q.c   <= |mul_acc_d[2*W-1:W];
                        flags_q.z   <= (mul_acc_d[W-1:0] == '0);
                        flags_q.n   <= mul_acc_d[W-1];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=16, MUL_EN=1): directed corner cases, backpressure,
// mid-multiply reset and randomized ops against an arithmetic reference.
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {result[15:0], v, c, z, n} from plain integer arithmetic.
    function automatic logic [19:0] ref_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int ua, ub, sa, sb, s;
        longint unsigned p;
        logic [15:0] r;
        logic v, c;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        v = 1'b0; c = 1'b0; r = '0;
        case (op)
            3'd0: begin
                r = 16'(ua + ub);
                c = (ua + ub) > 65535;
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = 16'(ua - ub);
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 16'd1 : 16'd0;
            3'd6: begin
                p = longint'(ua) * longint'(ub);
                r = p[15:0];
                c = (p > 64'd65535);
            end
            default: r = '0;
        endcase
        return {r, v, c, (r == 16'd0), r[15]};
    endfunction

    // One transaction; hold = cycles out_ready stays low once DONE is reached.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        logic [19:0] exp;
        int lat, exp_lat;
        exp     = ref_model(op, a, b);
        exp_lat = (op == 3'd6) ? W + 1 : 1;
        bus.out_ready = (hold == 0);
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("result", 32'(bus.result), 32'(exp[19:4]));
        check_eq("flags_vczn", 32'({bus.v, bus.c, bus.z, bus.n}), 32'(exp[3:0]));
        $display("op=%0d a=%h b=%h -> result=%h vczn=%b lat=%0d hold=%0d",
                 op, a, b, bus.result, {bus.v, bus.c, bus.z, bus.n}, lat, hold);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.op = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_result", 32'(bus.result), 32'(exp[19:4]));
            check_eq("hold_flags", 32'({bus.v, bus.c, bus.z, bus.n}), 32'(exp[3:0]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("back_idle_valid", 32'(bus.out_valid), 32'd0);
        check_eq("back_idle_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", 32'(bus.result), 32'd0);
        check_eq("rst_flags", 32'({bus.v, bus.c, bus.z, bus.n}), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        run_op(3'd0, 16'h0002, 16'h0003, 0);
        run_op(3'd1, 16'h0002, 16'h0003, 0);
        run_op(3'd1, 16'h0081, 16'h0004, 0);
        run_op(3'd0, 16'h7FFF, 16'h001E, 0);
        run_op(3'd5, 16'h7FFF, 16'h8000, 0);
        run_op(3'd5, 16'h8000, 16'h7FFF, 0);
        run_op(3'd6, 16'h0100, 16'h0100, 0);
        run_op(3'd6, 16'h00FF, 16'h0003, 0);
        run_op(3'd6, 16'hFFFF, 16'hFFFF, 1);
        run_op(3'd4, 16'hAAAA, 16'h5555, 5);
        run_op(3'd7, 16'h1234, 16'h5678, 0);

        // Reset four cycles into a multiply: nothing may be delivered.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 3'd6; bus.a = 16'h0123; bus.b = 16'h0456;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mulrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mulrst_result", 32'(bus.result), 32'd0);
        check_eq("mulrst_flags", 32'({bus.v, bus.c, bus.z, bus.n}), 32'd0);
        check_eq("mulrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        check_eq("mulrst_no_result", 32'(seen), 32'd0);
        run_op(3'd0, 16'h0001, 16'h0001, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
